// File: rtl/parity_engine_ctrl.sv
// Round-robin arbiter sharing one parity engine across streaming requesters.
// Optional stall timeout: define PARITY_CTRL_TIMEOUT_EN.
module parity_engine_ctrl #(
  parameter int DATA_WIDTH = 256,
  parameter int NUM_REQ    = 2,
  parameter int ENG_LAT    = 1,
  parameter int TIMEOUT    = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              in_valid,
  input  logic [NUM_REQ-1:0]              in_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   in_data,
  output logic [NUM_REQ-1:0]              in_ready,
  output logic                            eng_enable,
  output logic [DATA_WIDTH-1:0]           eng_data,
  input  logic [DATA_WIDTH-1:0]           eng_result,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [DATA_WIDTH-1:0]           res_data,
  output logic [$clog2(NUM_REQ)-1:0]      res_id,
  output logic                            res_err
);

  localparam int IW = $clog2(NUM_REQ);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] RESULT = 2'd3;

  logic [1:0]            state;
  logic [1:0]            state_n;
  logic [IW-1:0]         gnt;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         nxt;
  logic                  any;
  int                    idx;
  logic [DATA_WIDTH-1:0] acc;
  logic                  do_grant;
  logic                  accept;
  logic                  last_acc;
  logic                  emerge;
  logic                  pending;
  logic                  timeout_hit;

  // First requester at or after ptr; reverse scan keeps the nearest one.
  always_comb begin
    any = 1'b0;
    nxt = '0;
    idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (in_valid[IW'(idx)]) begin
        any = 1'b1;
        nxt = IW'(idx);
      end
    end
  end

  assign do_grant = (state == IDLE) && res_ready && any;
  assign accept   = (state == STREAM) && res_ready && in_valid[gnt];
  assign last_acc = accept && in_last[gnt];

  always_comb begin
    in_ready = '0;
    if (state == STREAM && res_ready)
      in_ready = NUM_REQ'(1) << gnt;
  end

  assign eng_enable = accept;
  assign eng_data   = accept
                    ? in_data[int'(gnt)*DATA_WIDTH +: DATA_WIDTH]
                    : '0;

  generate
    if (ENG_LAT == 0) begin : g_lat0
      assign emerge  = accept;
      assign pending = 1'b0;
    end else begin : g_lat
      localparam logic [ENG_LAT-1:0] TOP = 1 << (ENG_LAT - 1);
      logic [ENG_LAT-1:0] tags;

      always_ff @(posedge clk) begin
        if (rst)
          tags <= '0;
        else
          tags <= (tags << 1) | ENG_LAT'(accept);
      end

      assign emerge  = tags[ENG_LAT-1];
      // The emerging tag is absorbed this cycle, so it no longer counts.
      assign pending = |(tags & ~TOP);
    end
  endgenerate

`ifdef PARITY_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] idle_cnt;
  logic          err;

  always_ff @(posedge clk) begin
    if (rst)
      idle_cnt <= '0;
    else if (state != STREAM || in_valid[gnt])
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end

  assign timeout_hit = (state == STREAM) && !in_valid[gnt]
                     && (idle_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst)
      err <= 1'b0;
    else if (do_grant)
      err <= 1'b0;
    else if (timeout_hit)
      err <= 1'b1;
  end

  assign res_err = err;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign res_err        = 1'b0;
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (do_grant)
          state_n = STREAM;
      end
      STREAM: begin
        if (last_acc)
          state_n = (ENG_LAT == 0) ? RESULT : DRAIN;
        else if (timeout_hit)
          state_n = DRAIN;
      end
      DRAIN: begin
        if (!pending)
          state_n = RESULT;
      end
      RESULT: begin
        if (res_ready)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
      acc   <= '0;
    end else begin
      state <= state_n;
      if (do_grant) begin
        gnt <= nxt;
        acc <= '0;
      end else if (emerge) begin
        acc <= acc ^ eng_result;
      end
      if (state == RESULT && res_ready)
        ptr <= (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;
    end
  end

  assign res_valid = (state == RESULT);
  assign res_data  = acc;
  assign res_id    = gnt;

endmodule

// File: tb/tb_parity_engine_ctrl.sv
// Bench for parity_engine_ctrl: registered-identity engine, per-requester
// beat queues and a result scoreboard.
module tb_parity_engine_ctrl;

  localparam int DW = 256;
  localparam int NR = 2;
  localparam int IW = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] in_valid = '0;
  logic [NR-1:0] in_last = '0;
  logic [NR*DW-1:0] in_data = '0;
  logic [NR-1:0] in_ready;
  logic          eng_enable;
  logic [DW-1:0] eng_data;
  logic [DW-1:0] eng_result = '0;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [DW-1:0] res_data;
  logic [IW-1:0] res_id;
  logic          res_err;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  beat_t bq[NR][$];
  exp_t  sb[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int en_cnt = 0;

  always #5 clk = ~clk;

  parity_engine_ctrl #(
    .DATA_WIDTH(DW),
    .NUM_REQ(NR),
    .ENG_LAT(1),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_data(in_data),
    .in_ready(in_ready),
    .eng_enable(eng_enable),
    .eng_data(eng_data),
    .eng_result(eng_result),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .res_id(res_id),
    .res_err(res_err)
  );

  always @(posedge clk) cyc++;

  always @(posedge clk) eng_result <= eng_data;

  logic [NR-1:0] took;
  always @(posedge clk) begin
    took = in_valid & in_ready & {NR{!rst}};
    #1;
    for (int i = 0; i < NR; i++) begin
      if (took[i] && bq[i].size() > 0)
        void'(bq[i].pop_front());
      if (bq[i].size() > 0) begin
        in_valid[i] = 1'b1;
        in_last[i]  = bq[i][0].last;
        in_data[i*DW +: DW] = bq[i][0].data;
      end else begin
        in_valid[i] = 1'b0;
        in_last[i]  = 1'b0;
        in_data[i*DW +: DW] = '0;
      end
    end
  end

  exp_t e;
  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if (!$onehot0(in_ready)) begin
        n_fail++;
        $display("FAIL in_ready_onehot got=%b", in_ready);
      end
      n_checks++;
      if (eng_enable !== |(in_valid & in_ready)) begin
        n_fail++;
        $display("FAIL eng_enable got=%b want=%b", eng_enable,
                 |(in_valid & in_ready));
      end
      n_checks++;
      if (!eng_enable && eng_data !== '0) begin
        n_fail++;
        $display("FAIL eng_data_idle got=%h want=0", eng_data);
      end
      if (eng_enable) en_cnt++;
      if (res_valid && res_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result id=%0d data=%h", res_id, res_data);
        end else begin
          e = sb.pop_front();
          if ({res_id, res_data, res_err} !== {e.id, e.data, e.err}) begin
            n_fail++;
            $display("FAIL result got id=%0d err=%b data=%h want id=%0d err=%b data=%h",
                     res_id, res_err, res_data, e.id, e.err, e.data);
          end
        end
      end
    end
  end

  task automatic push_beat(int id, logic [DW-1:0] d, logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    bq[id].push_back(b);
  endtask

  task automatic push_exp(int id, logic [DW-1:0] d, logic err);
    exp_t x;
    x.id = IW'(id);
    x.data = d;
    x.err = err;
    sb.push_back(x);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && bq[0].size() == 0 && bq[1].size() == 0
          && !res_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({in_ready, eng_enable, res_valid, res_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl got rdy=%b en=%b rv=%b err=%b want 0",
               in_ready, eng_enable, res_valid, res_err);
    end
    n_checks++;
    if (eng_data !== '0 || res_data !== '0 || res_id !== '0) begin
      n_fail++;
      $display("FAIL reset_data got eng=%h res=%h id=%0d want 0",
               eng_data, res_data, res_id);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single;
    int t0 = -1;
    int t1 = -1;
    bit ok;
    push_beat(0, 256'h1, 1'b1);
    push_exp(0, 256'h1, 1'b0);
    for (int i = 0; i < 50 && t0 < 0; i++) begin
      @(negedge clk);
      if (in_valid[0] && in_ready[0]) t0 = cyc;
    end
    for (int i = 0; i < 50 && t1 < 0; i++) begin
      @(negedge clk);
      if (res_valid) t1 = cyc;
    end
    n_checks++;
    if (t0 < 0 || t1 < 0 || t1 - t0 != 2) begin
      n_fail++;
      $display("FAIL single_latency got=%0d want=2", t1 - t0);
    end
    wait_done(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_done got=timeout want=done");
    end
  endtask

  task automatic test_multi;
    bit ok;
    en_cnt = 0;
    push_beat(1, 256'hF0, 1'b0);
    push_beat(1, 256'h0F, 1'b0);
    push_beat(1, 256'hFF, 1'b1);
    push_exp(1, 256'h0, 1'b0);
    wait_done(ok);
    n_checks++;
    if (!ok || en_cnt != 3) begin
      n_fail++;
      $display("FAIL multi_enable got=%0d ok=%b want=3", en_cnt, ok);
    end
  endtask

  task automatic test_round_robin;
    bit ok;
    rst = 1'b1;
    push_beat(0, 256'h11, 1'b1);
    push_beat(0, 256'h13, 1'b1);
    push_beat(1, 256'h21, 1'b1);
    push_beat(1, 256'h23, 1'b1);
    push_exp(0, 256'h11, 1'b0);
    push_exp(1, 256'h21, 1'b0);
    push_exp(0, 256'h13, 1'b0);
    push_exp(1, 256'h23, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_done(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rr_done got=timeout want=done");
    end
  endtask

  task automatic test_backpressure;
    bit seen = 1'b0;
    bit ok;
    push_beat(0, 256'h55, 1'b1);
    push_beat(1, 256'h66, 1'b1);
    push_exp(0, 256'h55, 1'b0);
    push_exp(1, 256'h66, 1'b0);
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (in_valid[0] && in_ready[0]) seen = 1'b1;
    end
    @(posedge clk);
    #1 res_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_checks++;
      if (!res_valid || res_data !== 256'h55 || res_id !== 1'b0
          || in_ready !== '0) begin
        n_fail++;
        $display("FAIL bp_hold got rv=%b id=%0d rdy=%b data=%h want rv=1 id=0 rdy=0 data=55",
                 res_valid, res_id, in_ready, res_data);
      end
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    wait_done(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bp_done got=timeout want=done");
    end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    bit ok;
    push_beat(0, 256'h1, 1'b0);
    push_beat(0, 256'h2, 1'b0);
    push_beat(0, 256'h3, 1'b0);
    push_beat(0, 256'h4, 1'b1);
    for (int i = 0; i < 50 && n < 2; i++) begin
      @(negedge clk);
      if (in_valid[0] && in_ready[0]) n++;
    end
    @(posedge clk);
    #1 rst = 1'b1;
    bq[0].delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({in_ready, eng_enable, res_valid, res_err, res_id} !== '0
        || eng_data !== '0 || res_data !== '0) begin
      n_fail++;
      $display("FAIL rst_mid got rdy=%b en=%b rv=%b id=%0d data=%h want all 0",
               in_ready, eng_enable, res_valid, res_id, res_data);
    end
    push_beat(0, 256'hA, 1'b1);
    push_exp(0, 256'hA, 1'b0);
    wait_done(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rst_mid_done got=timeout want=done");
    end
  endtask

`ifdef PARITY_CTRL_TIMEOUT_EN
  task automatic test_timeout;
    int t0 = -1;
    int t1 = -1;
    bit ok;
    rst = 1'b1;
    push_beat(0, 256'h3, 1'b0);
    push_beat(1, 256'h7, 1'b1);
    push_exp(0, 256'h3, 1'b1);
    push_exp(1, 256'h7, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 50 && t0 < 0; i++) begin
      @(negedge clk);
      if (in_valid[0] && in_ready[0]) t0 = cyc;
    end
    for (int i = 0; i < 80 && t1 < 0; i++) begin
      @(negedge clk);
      if (res_valid) t1 = cyc;
    end
    n_checks++;
    if (t0 < 0 || t1 < 0 || t1 - t0 != 18) begin
      n_fail++;
      $display("FAIL timeout_latency got=%0d want=18", t1 - t0);
    end
    wait_done(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL timeout_done got=timeout want=done");
    end
  endtask
`else
  task automatic test_no_timeout;
    bit rose = 1'b0;
    bit ok;
    push_beat(0, 256'h3, 1'b0);
    repeat (40) begin
      @(negedge clk);
      if (res_valid) rose = 1'b1;
    end
    n_checks++;
    if (rose || in_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL no_timeout got rose=%b rdy=%b want rose=0 rdy=01",
               rose, in_ready);
    end
    push_beat(0, 256'h5, 1'b1);
    push_exp(0, 256'h6, 1'b0);
    wait_done(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL no_timeout_done got=timeout want=done");
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
`ifdef PARITY_CTRL_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left got=%0d want=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
